// File: rtl/gate_vec_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_vec_sequencer_if
//  Description : Bundle between the bring-up controller / gate datapath
//                (master side) and the gate vector sequencer (slave side).
//                master drives : start, abort, dut_y
//                slave drives  : vec_out, busy, done, pass, aborted,
//                                err_cnt, first_err_vec
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_vec_sequencer_if;
  logic       start;          // one-cycle sweep request
  logic       abort;          // terminate running sweep
  logic       dut_y;          // datapath output under test
  logic [3:0] vec_out;        // stimulus {a,b,c,d}
  logic       busy;           // not idle
  logic       done;           // one-cycle end-of-sweep pulse
  logic       pass;           // completed sweep with zero mismatches
  logic       aborted;        // last sweep ended via abort
  logic [4:0] err_cnt;        // mismatch count 0..16
  logic [3:0] first_err_vec;  // index of first mismatch

  modport master (
    output start, abort, dut_y,
    input  vec_out, busy, done, pass, aborted, err_cnt, first_err_vec
  );

  modport slave (
    input  start, abort, dut_y,
    output vec_out, busy, done, pass, aborted, err_cnt, first_err_vec
  );
endinterface
`default_nettype wire

// File: rtl/gate_vec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_vec_sequencer
//  Description : Sweeps all 16 {a,b,c,d} combinations into the gate datapath,
//                holding each for HOLD_CYCLES+1 cycles, and compares the
//                sampled dut_y against y = ~(b & c) | d. Reports mismatch
//                count, first failing vector, pass and aborted status.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - gate_vec_sequencer_if.slave (control + datapath)
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_vec_sequencer #(
  parameter int HOLD_CYCLES = 4   // legal range 1..255
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  gate_vec_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state_q,     state_d;
  logic [3:0] idx_q,       idx_d;
  logic [7:0] hold_q,      hold_d;
  logic [4:0] err_cnt_q,   err_cnt_d;
  logic [3:0] first_err_q, first_err_d;
  logic       pass_q,      pass_d;
  logic       aborted_q,   aborted_d;

  logic       w_y_exp;
  logic       w_mismatch;

  // Golden function with a=idx[3], b=idx[2], c=idx[1], d=idx[0].
  assign w_y_exp    = ~(idx_q[2] & idx_q[1]) | idx_q[0];
  assign w_mismatch = (bus.dut_y != w_y_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      hold_q      <= 8'd0;
      err_cnt_q   <= 5'd0;
      first_err_q <= 4'd0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    aborted_d   = aborted_q;

    case (state_q)
      S_IDLE: begin
        // start has priority; abort alone does nothing here.
        if (bus.start) begin
          err_cnt_d   = 5'd0;
          first_err_d = 4'd0;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
          idx_d       = 4'd0;
          hold_d      = C_HOLD_LOAD;
          state_d     = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (hold_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end

      S_SAMPLE: begin
        // An abort here discards this cycle's comparison.
        if (bus.abort) begin
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          if (w_mismatch) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (err_cnt_q == 5'd0) begin
              first_err_d = idx_q;
            end
          end
          // Terminate on the last index rather than relying on wrap.
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            hold_d  = C_HOLD_LOAD;
            state_d = S_DRIVE;
          end
        end
      end

      S_DONE: begin
        pass_d  = (err_cnt_q == 5'd0);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.vec_out       = (state_q == S_IDLE) ? 4'd0 : idx_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass          = pass_q;
  assign bus.aborted       = aborted_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vec = first_err_q;

endmodule
`default_nettype wire
